// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with word-serial line refill.
// Define ICACHE_STATS_EN to add the hit_count / miss_count statistics ports.
module icache_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        ihit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t             r_state, w_next_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES][WORDS_PER_LINE];
  logic [31:0]        r_base;
  logic [OFF_W-1:0]   r_cnt;
  logic               r_flush_pend;

  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_lookup_hit;
  logic               w_start_refill;
  logic               w_fill_word;
  logic               w_fill_done;
  logic               w_unused;

  assign w_idx        = pc[2+OFF_W +: IDX_W];
  assign w_off        = pc[2 +: OFF_W];
  assign w_tag        = pc[31 -: TAG_W];
  assign w_fill_idx   = r_base[2+OFF_W +: IDX_W];
  assign w_fill_tag   = r_base[31 -: TAG_W];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused     = ^pc[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state   = r_state;
    ihit           = 1'b0;
    instr          = '0;
    mem_req        = 1'b0;
    mem_addr       = '0;
    w_start_refill = 1'b0;
    w_fill_word    = 1'b0;
    w_fill_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ihit = w_lookup_hit;
        if (w_lookup_hit) begin
          instr = r_data[w_idx][w_off];
        end else begin
          w_start_refill = 1'b1;
          w_next_state   = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req     = 1'b1;
        mem_addr    = r_base + (32'(r_cnt) << 2);
        w_fill_word = mem_ack;
        if (mem_ack && (&r_cnt)) begin
          w_fill_done  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register in the
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid      <= '0;
      r_base       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (r_state == S_IDLE && flush) r_valid <= '0;
      if (w_start_refill) begin
        r_base       <= {pc[31:2+OFF_W], {(2+OFF_W){1'b0}}};
        r_cnt        <= '0;
        r_flush_pend <= 1'b0;
      end
      if (w_fill_word) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_REFILL && flush) r_flush_pend <= 1'b1;
      // A flush seen at any point of the refill wipes everything, including this line.
      if (w_fill_done) begin
        r_flush_pend <= 1'b0;
        if (r_flush_pend || flush) r_valid <= '0;
        else                       r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (w_fill_word) r_data[w_fill_idx][r_cnt] <= mem_rdata;
    if (w_fill_done) r_tag[w_fill_idx] <= w_fill_tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit)           hit_count  <= hit_count + 32'd1;
      if (w_start_refill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a line-residency model predicts hits, refill
// addresses and latencies; monitors compare against the DUT on the falling edge.
module tb_icache_ctrl;
  localparam int LINES      = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;
  localparam logic [31:0] SALT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rstn, flush, mem_ack, ihit, mem_req;
  logic [31:0] pc, instr, mem_addr, mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_ctrl #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pc        (pc),
    .flush     (flush),
    .instr     (instr),
    .ihit      (ihit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory image: every word is its own address scrambled.
  assign mem_rdata = mem_addr ^ SALT;

  typedef struct {
    logic [31:0] exp_instr;
    int          t0;
    int          lat;
    bit          exact;
  } tx_t;

  tx_t         txq[$];
  logic [31:0] addrq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ack_mode = 0;
  bit          mvalid[LINES];
  logic [31:0] mbase[LINES];
  int          exp_hits = 0;
  int          exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (cyc % 3 == 0);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: memory-side address sequence and fetch-side responses.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    tx_t e;
    if (rstn) begin
      if (mem_req) begin
        if (addrq.size() == 0) fail("unexpected_mem_req");
        if (prev_req && !prev_ack) check("mem_addr_hold", mem_addr, prev_addr);
        if (mem_ack && addrq.size() != 0) check("mem_addr", mem_addr, addrq.pop_front());
      end
      if (ihit) begin
        if (txq.size() == 0) begin
          fail("unexpected_ihit");
        end else begin
          e = txq.pop_front();
          check("instr", instr, e.exp_instr);
          if (e.exact) check("latency", 32'(cyc - e.t0), 32'(e.lat));
          else         check("latency_min", 32'((cyc - e.t0) >= e.lat), 32'd1);
        end
      end
    end
    prev_req  <= mem_req && rstn;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
  end

  // One fetch: hold pc until the hit. fl flushes in the issue cycle; mid_k > 0
  // flushes in the cycle after the mid_k-th refill ack.
  task automatic fetch(input logic [31:0] a, input bit fl, input int mid_k);
    int          i = idx_of(a);
    logic [31:0] b = base_of(a);
    bit          hit = mvalid[i] && (mbase[i] == b);
    tx_t         e;
    int          acks = 0;
    bit          done = 1'b0;
    bit          fdone = 1'b0;
    e.exp_instr = (a & ~32'h3) ^ SALT;
    e.t0        = cyc;
    e.exact     = hit || (ack_mode == 0);
    e.lat       = 0;
    if (!hit) begin
      for (int w = 0; w < WPL; w++) addrq.push_back(b + 32'(4 * w));
      exp_misses++;
      e.lat = WPL + 1;
      if (mid_k > 0) begin
        for (int w = 0; w < WPL; w++) addrq.push_back(b + 32'(4 * w));
        exp_misses++;
        e.lat = 2 * (WPL + 1);
      end
    end
    exp_hits++;
    if (fl || (!hit && mid_k > 0)) clear_model();
    if (!hit) begin
      mvalid[i] = 1'b1;
      mbase[i]  = b;
    end
    txq.push_back(e);
    pc    = a;
    flush = fl;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (ihit) begin
        done = 1'b1;
      end else begin
        if (mem_req && mem_ack) acks++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (mid_k > 0 && !fdone && acks == mid_k) begin
          flush = 1'b1;
          fdone = 1'b1;
        end
      end
    end
    if (!done) begin
      fail("fetch_timeout");
      txq.delete();
      addrq.delete();
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic reset_mid(input logic [31:0] a);
    logic [31:0] b = base_of(a);
    int          acks = 0;
    for (int w = 0; w < WPL; w++) addrq.push_back(b + 32'(4 * w));
    pc = a;
    for (int c = 0; c < 200 && acks < 2; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
    end
    if (acks < 2) fail("reset_mid_no_acks");
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_ihit", 32'(ihit), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_mid_hit_count", hit_count, 32'd0);
    check("rst_mid_miss_count", miss_count, 32'd0);
`endif
    txq.delete();
    addrq.delete();
    clear_model();
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    fetch(a, 1'b0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    pc    = 32'h0;
    flush = 1'b0;
    clear_model();
    #1;
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("post_reset_ihit", 32'(ihit), 32'd0);
    fetch(32'h0, 1'b0, 0);

    fetch(32'h100, 1'b0, 0);
    fetch(32'h10C, 1'b0, 0);
    fetch(32'h200, 1'b0, 0);
    fetch(32'h100, 1'b0, 0);

    ack_mode = 1;
    fetch(32'h344, 1'b0, 0);
    fetch(32'h348, 1'b0, 0);

    ack_mode = 0;
    fetch(32'h400, 1'b0, 2);
    fetch(32'h408, 1'b1, 0);
    fetch(32'h408, 1'b0, 0);
    fetch(32'h344, 1'b0, 0);

    reset_mid(32'h3000);

    for (int n = 0; n < 300; n++) begin
      ack_mode = int'($urandom_range(0, 2));
      fetch(32'($urandom_range(0, 3 * LINES * LINE_BYTES - 1)),
            ($urandom_range(0, 15) == 0), 0);
    end

`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif
    if (txq.size() != 0) fail("tx_left_over");
    if (addrq.size() != 0) fail("refill_words_left_over");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
